// File: rtl/snake_move_ctrl.sv
// Snake head movement controller.
// Paces the head with a free-running tick counter and filters direction
// requests so the head never turns straight back on itself. The playfield
// wraps at every edge. Game flow is IDLE -> RUN <-> PAUSED, RUN -> DEAD -> RUN.
module snake_move_ctrl #(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int XW          = 5,
  parameter int YW          = 5,
  parameter int MOVE_PERIOD = 5000000,
  parameter int CW          = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    direction,
  input  logic          start,
  input  logic          pause,
  input  logic          collide,
  output logic          step,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [2:0]    cur_dir,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DEAD   = 2'b11
  } state_t;

  localparam logic [2:0]    DIR_LEFT  = 3'b001;
  localparam logic [2:0]    DIR_RIGHT = 3'b010;
  localparam logic [2:0]    DIR_UP    = 3'b011;
  localparam logic [2:0]    DIR_DOWN  = 3'b100;

  localparam logic [XW-1:0] X_MID    = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_MID    = YW'(GRID_H / 2);
  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_ZERO   = XW'(0);
  localparam logic [YW-1:0] Y_ZERO   = YW'(0);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_PERIOD - 1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          step_r;
  logic [XW-1:0] head_x_r;
  logic [YW-1:0] head_y_r;
  logic [2:0]    cur_dir_r;
  logic [2:0]    pend_r;

  logic [2:0]    pend_next_s;
  logic [XW-1:0] next_x_s;
  logic [YW-1:0] next_y_s;

  // True for the four legal direction codes.
  function automatic logic dir_valid(input logic [2:0] d);
    case (d)
      DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // True when request req points exactly opposite to heading cur.
  function automatic logic is_reverse(input logic [2:0] req, input logic [2:0] cur);
    case (req)
      DIR_LEFT:  return (cur == DIR_RIGHT);
      DIR_RIGHT: return (cur == DIR_LEFT);
      DIR_UP:    return (cur == DIR_DOWN);
      DIR_DOWN:  return (cur == DIR_UP);
      default:   return 1'b1;
    endcase
  endfunction

  // Filter this cycle's request into the pending heading and compute the wrapped next cell.
  always_comb begin
    pend_next_s = pend_r;
    next_x_s    = head_x_r;
    next_y_s    = head_y_r;
    if (dir_valid(direction) && !is_reverse(direction, cur_dir_r)) begin
      pend_next_s = direction;
    end else begin
      pend_next_s = pend_r;
    end
    case (pend_next_s)
      DIR_LEFT:  next_x_s = (head_x_r == X_ZERO) ? X_MAX  : head_x_r - X_ONE;
      DIR_RIGHT: next_x_s = (head_x_r == X_MAX)  ? X_ZERO : head_x_r + X_ONE;
      DIR_UP:    next_y_s = (head_y_r == Y_ZERO) ? Y_MAX  : head_y_r - Y_ONE;
      DIR_DOWN:  next_y_s = (head_y_r == Y_MAX)  ? Y_ZERO : head_y_r + Y_ONE;
      default: begin
        next_x_s = head_x_r;
        next_y_s = head_y_r;
      end
    endcase
  end

  // Game FSM, move pacing, heading and head position, all registered together.
  // The RUN cycle that leaves for PAUSED still counts as a RUN cycle, so a
  // pause only stretches the period by the number of cycles spent in PAUSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      step_r    <= 1'b0;
      head_x_r  <= X_MID;
      head_y_r  <= Y_MID;
      cur_dir_r <= DIR_RIGHT;
      pend_r    <= DIR_RIGHT;
    end else begin
      step_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DEAD: begin
          cnt_r <= CNT_ZERO;
          if (start) begin
            state_r   <= ST_RUN;
            head_x_r  <= X_MID;
            head_y_r  <= Y_MID;
            cur_dir_r <= DIR_RIGHT;
            pend_r    <= DIR_RIGHT;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (collide) begin
            // Collision beats both pause and a terminal-count step.
            state_r <= ST_DEAD;
            cnt_r   <= CNT_ZERO;
          end else begin
            pend_r <= pend_next_s;
            if (cnt_r == CNT_LAST) begin
              cnt_r     <= CNT_ZERO;
              step_r    <= 1'b1;
              cur_dir_r <= pend_next_s;
              head_x_r  <= next_x_s;
              head_y_r  <= next_y_s;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
            if (pause) begin
              state_r <= ST_PAUSED;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_PAUSED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign step    = step_r;
  assign head_x  = head_x_r;
  assign head_y  = head_y_r;
  assign cur_dir = cur_dir_r;
  assign state   = state_r;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl on an 8x4 grid with a 4-cycle move period.
module tb_snake_move_ctrl;

  localparam int GRID_W = 8;
  localparam int GRID_H = 4;
  localparam int XW     = 3;
  localparam int YW     = 2;
  localparam int MP     = 4;
  localparam int CW     = 3;

  logic          clk;
  logic          rst_n;
  logic [2:0]    direction;
  logic          start;
  logic          pause;
  logic          collide;
  logic          step;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [2:0]    cur_dir;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] dir;
    logic       start;
    logic       pause;
    logic       collide;
    logic       estep;
    logic [2:0] ex;
    logic [1:0] ey;
    logic [2:0] edir;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];

  snake_move_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
    .MOVE_PERIOD(MP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .direction(direction), .start(start),
    .pause(pause), .collide(collide), .step(step), .head_x(head_x),
    .head_y(head_y), .cur_dir(cur_dir), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int es, input int ex,
                           input int ey, input int ed, input int est);
    check({tag, ".step"},    int'(step),    es);
    check({tag, ".head_x"},  int'(head_x),  ex);
    check({tag, ".head_y"},  int'(head_y),  ey);
    check({tag, ".cur_dir"}, int'(cur_dir), ed);
    check({tag, ".state"},   int'(state),   est);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [2:0] d, input logic s, input logic p,
                              input logic c, input logic es, input logic [2:0] ex,
                              input logic [1:0] ey, input logic [2:0] ed,
                              input logic [1:0] est);
    vec_t v;
    v.dir = d; v.start = s; v.pause = p; v.collide = c;
    v.estep = es; v.ex = ex; v.ey = ey; v.edir = ed; v.est = est;
    vecs.push_back(v);
  endfunction

  // One full move period in RUN: three quiet cycles, then the step cycle.
  function automatic void add_period(input logic [2:0] d,
                                     input logic [2:0] ox, input logic [1:0] oy, input logic [2:0] od,
                                     input logic [2:0] nx, input logic [1:0] ny, input logic [2:0] nd);
    for (int k = 0; k < 3; k++) add(d, 1'b0, 1'b0, 1'b0, 1'b0, ox, oy, od, 2'b01);
    add(d, 1'b0, 1'b0, 1'b0, 1'b1, nx, ny, nd, 2'b01);
  endfunction

  initial begin
    rst_n = 1'b0; direction = 3'b000; start = 1'b0; pause = 1'b0; collide = 1'b0;

    // Start, four right moves with wrap at x=7.
    add(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 2'd2, 3'b010, 2'b01);
    add_period(3'b000, 3'd4, 2'd2, 3'b010, 3'd5, 2'd2, 3'b010);
    add_period(3'b000, 3'd5, 2'd2, 3'b010, 3'd6, 2'd2, 3'b010);
    add_period(3'b000, 3'd6, 2'd2, 3'b010, 3'd7, 2'd2, 3'b010);
    add_period(3'b000, 3'd7, 2'd2, 3'b010, 3'd0, 2'd2, 3'b010);
    // Reverse request is dropped, then turn up.
    add_period(3'b001, 3'd0, 2'd2, 3'b010, 3'd1, 2'd2, 3'b010);
    add_period(3'b011, 3'd1, 2'd2, 3'b010, 3'd1, 2'd1, 3'b011);
    add_period(3'b000, 3'd1, 2'd1, 3'b011, 3'd1, 2'd0, 3'b011);
    add_period(3'b000, 3'd1, 2'd0, 3'b011, 3'd1, 2'd3, 3'b011);
    // Right, then down through the bottom edge.
    add_period(3'b010, 3'd1, 2'd3, 3'b011, 3'd2, 2'd3, 3'b010);
    add_period(3'b100, 3'd2, 2'd3, 3'b010, 3'd2, 2'd0, 3'b100);
    // Left through the left edge, then a reverse right is dropped.
    add_period(3'b001, 3'd2, 2'd0, 3'b100, 3'd1, 2'd0, 3'b001);
    add_period(3'b000, 3'd1, 2'd0, 3'b001, 3'd0, 2'd0, 3'b001);
    add_period(3'b000, 3'd0, 2'd0, 3'b001, 3'd7, 2'd0, 3'b001);
    add_period(3'b010, 3'd7, 2'd0, 3'b001, 3'd6, 2'd0, 3'b001);
    // Two valid requests in one period: the later one wins.
    add(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 2'd0, 3'b001, 2'b01);
    add(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 2'd0, 3'b001, 2'b01);
    add(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 2'd0, 3'b001, 2'b01);
    add(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 2'd1, 3'b100, 2'b01);

    // Reset values while rst_n is low.
    #12;
    check_all("reset", 0, 4, 2, 2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("idle", 0, 4, 2, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      direction = vecs[i].dir;
      start     = vecs[i].start;
      pause     = vecs[i].pause;
      collide   = vecs[i].collide;
      tick();
      check_all($sformatf("vec%0d", i), int'(vecs[i].estep), int'(vecs[i].ex),
                int'(vecs[i].ey), int'(vecs[i].edir), int'(vecs[i].est));
    end
    direction = 3'b000; start = 1'b0;

    // Pause two cycles after a step; direction inputs ignored while paused.
    tick();
    check_all("pre_pause", 0, 6, 1, 4, 1);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("paused%0d", i), 0, 6, 1, 4, 2);
      direction = 3'b001;
    end
    pause = 1'b0; direction = 3'b000;
    tick();
    check_all("resume0", 0, 6, 1, 4, 1);
    tick();
    check_all("resume1", 0, 6, 1, 4, 1);
    tick();
    check_all("resume_step", 1, 6, 2, 4, 1);

    // Collision on the terminal-count cycle beats the step.
    for (int i = 0; i < 3; i++) tick();
    collide = 1'b1;
    tick();
    check_all("collide_tc", 0, 6, 2, 4, 3);
    collide = 1'b0;
    tick();
    tick();
    check_all("dead_hold", 0, 6, 2, 4, 3);

    // Restart from DEAD; start held in RUN does not restart the period.
    start = 1'b1;
    tick();
    check_all("restart", 0, 4, 2, 2, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("start_in_run%0d", i), 0, 4, 2, 2, 1);
    end
    tick();
    check_all("start_in_run_step", 1, 5, 2, 2, 1);
    start = 1'b0;

    // Pause and collide together: collide wins.
    pause = 1'b1; collide = 1'b1;
    tick();
    check_all("pause_collide", 0, 5, 2, 2, 3);
    pause = 1'b0; collide = 1'b0; start = 1'b1;
    tick();
    check_all("restart2", 0, 4, 2, 2, 1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check_all("pre_reset_step", 1, 5, 2, 2, 1);

    // Asynchronous reset between clock edges while step is high.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 4, 2, 2, 0);
    tick();
    tick();
    check_all("reset_held", 0, 4, 2, 2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("post_reset%0d", i), 0, 4, 2, 2, 0);
    end
    start = 1'b1;
    tick();
    check_all("post_reset_start", 0, 4, 2, 2, 1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check_all("post_reset_step", 1, 5, 2, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
